// File: rtl/dsp_fir_pkg.sv
// Shared types, default RRC prototype and arithmetic helpers for the polyphase FIR.
package dsp_fir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } issue_state_e;

    localparam int RRC_TAPS = 33;

    // Root-raised-cosine prototype, 4 samples/symbol, symmetric about h[16].
    localparam logic signed [11:0] DEFAULT_RRC [RRC_TAPS] = '{
        -12'sd10,  -12'sd3,   12'sd11,  12'sd22,  12'sd24,  12'sd12,  -12'sd14, -12'sd44,
        -12'sd70,  -12'sd82,  -12'sd60, -12'sd4,  12'sd96,  12'sd333, 12'sd654, 12'sd952,
        12'sd1133,
        12'sd952,  12'sd654,  12'sd333, 12'sd96,  -12'sd4,  -12'sd60, -12'sd82, -12'sd70,
        -12'sd44,  -12'sd14,  12'sd12,  12'sd24,  12'sd22,  12'sd11,  -12'sd3,  -12'sd10
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Round half-up after an arithmetic right shift.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc, input int shift);
        logic signed [63:0] rnd;
        rnd = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
        return (acc + rnd) >>> shift;
    endfunction

    // True when the rounded value does not fit in out_w signed bits.
    function automatic logic sat_check(input logic signed [63:0] acc, input int shift, input int out_w);
        logic signed [63:0] t;
        t = round_shift(acc, shift);
        return (t > ((64'sd1 <<< (out_w - 1)) - 64'sd1)) || (t < -(64'sd1 <<< (out_w - 1)));
    endfunction

    // Round, then clamp to [-2^(out_w-1), 2^(out_w-1)-1].
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc, input int shift, input int out_w);
        logic signed [63:0] t;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        t  = round_shift(acc, shift);
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (t > hi) return hi;
        if (t < lo) return lo;
        return t;
    endfunction

endpackage

// File: rtl/fir_phase_mac.sv
// One channel of the polyphase FIR: L tap products, then sum / round / saturate.
module fir_phase_mac
    import dsp_fir_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int COEF_W = 12,
    parameter int L      = 9,
    parameter int ACC_W  = 18,
    parameter int OUT_W  = 14,
    parameter int SHIFT  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic                  vld_p0,
    input  logic                  vld_p1,
    input  logic [L*DATA_W-1:0]   hist,
    input  logic [L*COEF_W-1:0]   coefs,
    output logic [OUT_W-1:0]      out_data,
    output logic                  sat_hit
);
    localparam int PRD_W = DATA_W + COEF_W;

    logic signed [PRD_W-1:0] prod_p1_d [L];
    logic signed [PRD_W-1:0] prod_p1_q [L];
    logic signed [ACC_W-1:0] acc_p1;
    logic signed [63:0]      acc64_p1;
    logic [OUT_W-1:0]        out_d;
    logic [OUT_W-1:0]        out_q;
    logic                    hit_p1;

    // Stage p0 -> p1: multiply history by the selected phase's coefficients
    always_comb begin
        for (int k = 0; k < L; k++) begin
            prod_p1_d[k] = PRD_W'($signed(hist[k*DATA_W +: DATA_W]))
                         * PRD_W'($signed(coefs[k*COEF_W +: COEF_W]));
        end
    end

    // Product registers; data only, qualified by the valid pipeline
    always_ff @(posedge clk) begin
        if (adv && vld_p0) prod_p1_q <= prod_p1_d;
    end

    // Stage p1 -> p2: full-precision sum, round, saturate
    always_comb begin
        acc_p1 = '0;
        for (int k = 0; k < L; k++) begin
            acc_p1 = acc_p1 + ACC_W'(prod_p1_q[k]);
        end
        acc64_p1 = {{(64-ACC_W){acc_p1[ACC_W-1]}}, acc_p1};
        hit_p1   = sat_check(acc64_p1, SHIFT, OUT_W);
        out_d    = out_q;
        if (adv && vld_p1) out_d = OUT_W'(round_sat(acc64_p1, SHIFT, OUT_W));
    end

    // Output register holds while stalled or idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
    end

    assign out_data = out_q;
    assign sat_hit  = adv && vld_p1 && hit_p1;

endmodule

// File: rtl/polyphase_interp_fir.sv
// Multi-channel polyphase interpolating RRC FIR: issue FSM, symbol history,
// programmable coefficient table and one MAC per channel.
module polyphase_interp_fir
    import dsp_fir_pkg::*;
#(
    parameter int CH     = 2,
    parameter int DATA_W = 2,
    parameter int COEF_W = 12,
    parameter int TAPS   = 33,
    parameter int UPS    = 4,
    parameter int OUT_W  = 14,
    parameter int SHIFT  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH*DATA_W-1:0]      in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CH*OUT_W-1:0]       out_data,
    input  logic                      coef_we,
    input  logic [clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    output logic                      sat,
    input  logic                      sat_clr
);
    localparam int L     = (TAPS + UPS - 1) / UPS;
    localparam int ACC_W = DATA_W + COEF_W + clog2(L);
    localparam int PW    = clog2(UPS);

    issue_state_e            state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic signed [DATA_W-1:0] hist_q [CH][L];
    logic signed [DATA_W-1:0] hist_d [CH][L];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [COEF_W-1:0] coef_pad [UPS*L];
    logic                    vld_p1_q, vld_p1_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sat_q, sat_d;
    logic                    stall, adv, last_phase, accept, vld_p0;
    logic [L*COEF_W-1:0]     coef_sel;
    logic [L*DATA_W-1:0]     hist_flat [CH];
    logic [OUT_W-1:0]        mac_out [CH];
    logic [CH-1:0]           mac_sat;

    // Issue state register: FSM, phase counter and per-channel symbol history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            hist_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hist_q  <= hist_d;
        end
    end

    // Next issue state: accept shifts a symbol in, otherwise step through phases
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hist_d  = hist_q;
        if (accept) begin
            for (int c = 0; c < CH; c++) begin
                for (int k = L - 1; k > 0; k--) hist_d[c][k] = hist_q[c][k-1];
                hist_d[c][0] = in_data[c*DATA_W +: DATA_W];
            end
            phase_d = '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && !stall) begin
            if (last_phase) state_d = ST_IDLE;
            else            phase_d = phase_q + PW'(1);
        end
    end

    // Issue outputs: stall, handshake and issue-stage valid
    always_comb begin
        stall      = out_valid_q && !out_ready;
        adv        = !stall;
        last_phase = (phase_q == PW'(UPS - 1));
        in_ready   = !stall && (state_q == ST_IDLE || last_phase);
        accept     = in_valid && in_ready;
        vld_p0     = (state_q == ST_RUN);
    end

    // Coefficient table: reset to the default prototype, writable at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                coef_q[i] <= (i < RRC_TAPS) ? COEF_W'(DEFAULT_RRC[i]) : '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    // Coefficient write; addresses past the last tap are dropped
    always_comb begin
        coef_d = coef_q;
        if (coef_we && int'(coef_addr) < TAPS) coef_d[coef_addr] = coef_wdata;
    end

    // Taps beyond the prototype length read as zero
    for (genvar i = 0; i < UPS*L; i++) begin : g_pad
        if (i < TAPS) begin : g_tap
            assign coef_pad[i] = coef_q[i];
        end else begin : g_zero
            assign coef_pad[i] = '0;
        end
    end

    // Stage p0 operands: phase coefficients h[p+k*UPS] and flattened history
    always_comb begin
        coef_sel = '0;
        for (int k = 0; k < L; k++) begin
            for (int p = 0; p < UPS; p++) begin
                if (phase_q == PW'(p)) coef_sel[k*COEF_W +: COEF_W] = coef_pad[p + k*UPS];
            end
        end
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < L; k++) hist_flat[c][k*DATA_W +: DATA_W] = hist_q[c][k];
        end
    end

    // Valid pipeline and sticky saturation flag (set wins over clear)
    always_comb begin
        vld_p1_d    = adv ? vld_p0   : vld_p1_q;
        out_valid_d = adv ? vld_p1_q : out_valid_q;
        sat_d       = sat_q;
        if (sat_clr)  sat_d = 1'b0;
        if (|mac_sat) sat_d = 1'b1;
    end

    // Control registers of the sample pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        fir_phase_mac #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .L      (L),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W),
            .SHIFT  (SHIFT)
        ) u_mac (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .vld_p0   (vld_p0),
            .vld_p1   (vld_p1_q),
            .hist     (hist_flat[c]),
            .coefs    (coef_sel),
            .out_data (mac_out[c]),
            .sat_hit  (mac_sat[c])
        );
        assign out_data[c*OUT_W +: OUT_W] = mac_out[c];
    end

    assign out_valid = out_valid_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// Directed bench for polyphase_interp_fir with hand-computed expectations.
module tb_polyphase_interp_fir;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [27:0] out_data;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [11:0] coef_wdata = '0;
    logic        sat;
    logic        sat_clr = 1'b0;

    logic signed [13:0] out_i, out_q;
    assign out_i = out_data[13:0];
    assign out_q = out_data[27:14];

    int n_assert = 0;
    int n_fail   = 0;

    // Default prototype followed by three zero taps (phase padding).
    int h_exp [36] = '{-10, -3, 11, 22, 24, 12, -14, -44, -70, -82, -60, -4, 96, 333, 654, 952,
                       1133, 952, 654, 333, 96, -4, -60, -82, -70, -44, -14, 12, 24, 22, 11, -3,
                       -10, 0, 0, 0};
    int exp_tab [36];
    // Two symbols (I=+1,Q=-1) then (I=-2,Q=+1), outputs after edge E+k.
    int e2i [8] = '{0, 0, -10, -3, 11, 22, 44, 18};
    int e2q [8] = '{0, 0, 10, 3, -11, -22, -34, -15};
    int gi[$];
    int gq[$];

    always #5 clk = ~clk;

    polyphase_interp_fir dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .sat        (sat),
        .sat_clr    (sat_clr)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        sat_clr  = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we    = 1'b1;
        coef_addr  = 6'(a);
        coef_wdata = 12'(v);
        cyc();
        coef_we = 1'b0;
    endtask

    // Impulse on I (+1 then zeros), optional 5-cycle downstream stall.
    task automatic run_stream(input int nsym, input int stall_at);
        int sent;
        int n;
        sent = 0;
        n = 0;
        gi.delete();
        gq.delete();
        while (gi.size() < 36 && n < 300) begin
            out_ready = !(stall_at >= 0 && n >= stall_at && n < stall_at + 5);
            in_valid  = (sent < nsym);
            in_data   = (sent == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (out_valid && !out_ready) begin
                chk($sformatf("bp_in_ready_%0d", n), in_ready, 0);
                chk($sformatf("bp_hold_i_%0d", n), out_i, exp_tab[gi.size()]);
            end
            if (out_valid && out_ready) begin
                gi.push_back(out_i);
                gq.push_back(out_q);
            end
            if (in_valid && in_ready) sent++;
            n++;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", gi.size(), 36);
    endtask

    task automatic check_impulse(input string tag);
        for (int i = 0; i < gi.size(); i++) begin
            chk($sformatf("%s_i_%0d", tag, i), gi[i], exp_tab[i]);
            chk($sformatf("%s_q_%0d", tag, i), gq[i], 0);
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_in_ready", in_ready, 1);

        // 1: impulse with default coefficients
        do_reset();
        exp_tab = h_exp;
        run_stream(9, -1);
        check_impulse("imp");

        // 2: latency and throughput with continuous symbols
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'b1101;
        cyc();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("lat_valid_%0d", k), out_valid, (k >= 2) ? 1 : 0);
            chk($sformatf("thr_ready_%0d", k), in_ready, (k % 4 == 3) ? 1 : 0);
            if (k >= 2) begin
                chk($sformatf("lat_i_%0d", k), out_i, e2i[k]);
                chk($sformatf("lat_q_%0d", k), out_q, e2q[k]);
            end
            in_data = (k <= 3) ? 4'b0110 : 4'b0000;
            cyc();
        end
        for (int k = 8; k < 16; k++) begin
            #1;
            chk($sformatf("thr_valid_%0d", k), out_valid, 1);
            chk($sformatf("thr_ready_%0d", k), in_ready, (k % 4 == 3) ? 1 : 0);
            cyc();
        end
        in_valid = 1'b0;

        // 3: backpressure mid-stream, sequence must match the unstalled impulse
        do_reset();
        exp_tab = h_exp;
        run_stream(9, 10);
        check_impulse("bp");

        // 4: saturation with all taps at full scale
        do_reset();
        for (int a = 0; a < 33; a++) write_coef(a, 2047);
        in_data  = 4'b1101;
        in_valid = 1'b1;
        repeat (48) cyc();
        #1;
        chk("satp_valid", out_valid, 1);
        chk("satp_i", out_i, 8191);
        chk("satp_q", out_q, -8192);
        chk("satp_flag", sat, 1);
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        #1;
        chk("sat_set_wins", sat, 1);
        in_valid = 1'b0;
        repeat (8) cyc();
        #1;
        chk("sat_idle_valid", out_valid, 0);
        chk("sat_hold_i", out_i, 8191);
        chk("sat_hold_q", out_q, -8192);
        sat_clr = 1'b1;
        cyc();
        sat_clr = 1'b0;
        #1;
        chk("sat_cleared", sat, 0);
        in_data  = 4'b0111;
        in_valid = 1'b1;
        repeat (48) cyc();
        #1;
        chk("satn_i", out_i, -8192);
        chk("satn_q", out_q, 8191);
        chk("satn_flag", sat, 1);
        in_valid = 1'b0;

        // 5: reprogram centre tap while idle, out-of-range write ignored
        do_reset();
        write_coef(16, 0);
        write_coef(40, 555);
        exp_tab = h_exp;
        exp_tab[16] = 0;
        run_stream(9, -1);
        check_impulse("reprog");

        // 6: asynchronous reset in the middle of a burst
        do_reset();
        in_data  = 4'b0001;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        #1;
        chk("mid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1;
        chk("mid_post_valid", out_valid, 0);
        chk("mid_post_ready", in_ready, 1);
        in_data  = 4'b0001;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        #1;
        chk("mid_post_out_valid", out_valid, 1);
        chk("mid_post_hist_clear", out_i, -10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
